avl_bus_n21_wrr: RTL and testbench
==================================

Name: avl_bus_n21_wrr

Overview:
- Parametrised N-master to 1-slave Avalon-MM arbiter/multiplexer; next generation of the n21 stage used inside avl_bus_n2n.
- Adds selectable arbitration: fixed priority, round-robin, or weighted round-robin with per-master weights.
- Adds a parametrised read-return select FIFO with back-pressure, and a sticky error flag for readdatavalid that matches no outstanding read.
- Sits between master-side ports (CPU, DMA, debug) and one slave port (SDRAM controller, peripheral bridge).

Parameters:
- MASTER_NUM, 4, number of masters (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8); BE_W = DATA_W/8.
- ARB_METHOD, 0, arbitration mode: 0 round-robin, 1 fixed priority (index 0 highest), 2 weighted round-robin.
- WEIGHT_LIST, 64'h1111_1111_1111_1111, 4 bits per master, master i at [4i+3:4i]. A weight of 0 is treated as 1. Used only when ARB_METHOD=2.
- SEL_FIFO_DEPTH, 8, maximum outstanding reads (power of 2, >=2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rest  in  1  synchronous, active-high reset.
- m_read  in  MASTER_NUM  per-master read request.
- m_write  in  MASTER_NUM  per-master write request.
- m_address  in  MASTER_NUM*ADDR_W  packed; master i at [i*ADDR_W +: ADDR_W].
- m_byteenable  in  MASTER_NUM*BE_W  packed byte enables.
- m_writedata  in  MASTER_NUM*DATA_W  packed write data.
- m_waitrequest  out  MASTER_NUM  per-master stall.
- m_readdata  out  DATA_W  read data, broadcast to all masters.
- m_readdatavalid  out  MASTER_NUM  one-hot read return strobe.
- s_read, s_write  out  1  slave requests.
- s_address  out  ADDR_W  slave address.
- s_byteenable  out  BE_W  slave byte enables.
- s_writedata  out  DATA_W  slave write data.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.
- s_readdatavalid  in  1  slave read return.
- err_unexp_rdata  out  1  sticky flag: readdatavalid arrived with no outstanding read.

Behaviour:
- Request and eligibility:
  - req[i] = m_read[i] | m_write[i].
  - Master i is eligible if req[i] and not (m_read[i] and FIFO full).
  - Full is taken from the registered count, with no same-cycle pop bypass.
- Grant:
  - Combinational: the first eligible master scanning ptr, ptr+1, … with wrap modulo MASTER_NUM.
  - Fixed-priority mode always scans from 0.
  - No eligible master: s_read = s_write = 0, and s_address/s_byteenable/s_writedata = 0.
- Slave mux:
  - s_* carry the granted master's signals.
  - m_waitrequest[g] = s_waitrequest; every other master sees 1.
- Acceptance:
  - A transfer is accepted when a grant exists and s_waitrequest = 0.
  - Before acceptance, grant may move to a newly eligible higher-priority master; the displaced master simply keeps waiting.
  - m_read and m_write both high on the same master is illegal. The block issues the read and ignores the write.
- Arbitration state: ptr (log2 MASTER_NUM bits) and cnt (4 bits), updated only on acceptance by master g.
  - base = (g == ptr) ? cnt : 0; W = effective weight of g. Round-robin mode uses W = 1 for every master.
  - If base+1 < W: cnt <= base+1, ptr <= g.
  - Else: cnt <= 0, ptr <= (g+1) mod MASTER_NUM.
  - Fixed-priority mode leaves ptr and cnt at 0.
- Select FIFO:
  - Push the index of g on every accepted read.
  - Pop on s_readdatavalid when the FIFO is non-empty. m_readdatavalid[head] = 1 in that same cycle (combinational route); m_readdata = s_readdata always.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo SEL_FIFO_DEPTH; count is 0..SEL_FIFO_DEPTH.
- Unexpected return: s_readdatavalid with the FIFO empty gives no m_readdatavalid, and err_unexp_rdata <= 1 (sticky until rest).
- Writes carry no response, never touch the FIFO, and are accepted while the FIFO is full.
- Reset:
  - rest = 1 clears ptr, cnt, FIFO pointers/count and err_unexp_rdata.
  - Reads in flight are forgotten; their later returns set err_unexp_rdata.
  - During reset, outputs follow the combinational rules with the FIFO empty.
- Latency: zero added cycles on request and on return.

Test Plan:
1. Reset: rest=1 for 2 cycles, all requests 0 → s_read=s_write=0, m_waitrequest=4'b1111, m_readdatavalid=0, err_unexp_rdata=0.
2. Round-robin: ARB_METHOD=0, masters 0..3 read continuously, slave waitrequest=0, 2-cycle read latency, readdata = address → slave sees masters 0,1,2,3,0,1…; each m_readdatavalid is one-hot on the issuing master, in issue order, with matching data.
3. Fixed priority: ARB_METHOD=1, masters 1 and 3 write continuously for 10 cycles → all 10 grants go to 1. When master 1 drops, master 3 is granted the next cycle.
4. Weighted round-robin: ARB_METHOD=2, WEIGHT_LIST=...4321 (master0=1, 1=2, 2=3, 3=4), all masters requesting → grant sequence 0,1,1,2,2,2,3,3,3,3,0…. Insert s_waitrequest=1 for 3 cycles mid-sequence → sequence unchanged.
5. FIFO full: SEL_FIFO_DEPTH=4, slave never returns → 4 reads accepted, then m_waitrequest stays 1 for reads while master 2 writes are still accepted. One s_readdatavalid → the next read is accepted in the following cycle.
6. Spurious return: FIFO empty, s_readdatavalid=1 → all m_readdatavalid=0 and err_unexp_rdata=1, which holds until rest=1.

Source files
------------

// File: rtl/avl_bus_n21_wrr_if.sv
// Avalon-MM bundle for the N-to-1 arbiter: packed master-side ports plus the single slave port.
// Modports give the upstream masters' view, the downstream slave's view and the arbiter's view.
interface avl_bus_n21_wrr_if #(
  parameter int unsigned MASTER_NUM = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [MASTER_NUM-1:0]        m_read;
  logic [MASTER_NUM-1:0]        m_write;
  logic [MASTER_NUM*ADDR_W-1:0] m_address;
  logic [MASTER_NUM*BE_W-1:0]   m_byteenable;
  logic [MASTER_NUM*DATA_W-1:0] m_writedata;
  logic [MASTER_NUM-1:0]        m_waitrequest;
  logic [DATA_W-1:0]            m_readdata;
  logic [MASTER_NUM-1:0]        m_readdatavalid;

  logic                         s_read;
  logic                         s_write;
  logic [ADDR_W-1:0]            s_address;
  logic [BE_W-1:0]              s_byteenable;
  logic [DATA_W-1:0]            s_writedata;
  logic                         s_waitrequest;
  logic [DATA_W-1:0]            s_readdata;
  logic                         s_readdatavalid;

  modport master (
    output m_read, m_write, m_address, m_byteenable, m_writedata,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  s_read, s_write, s_address, s_byteenable, s_writedata,
    output s_waitrequest, s_readdata, s_readdatavalid
  );

  modport arb (
    input  m_read, m_write, m_address, m_byteenable, m_writedata,
    output m_waitrequest, m_readdata, m_readdatavalid,
    output s_read, s_write, s_address, s_byteenable, s_writedata,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/avl_bus_n21_wrr.sv
// N-master to 1-slave Avalon-MM arbiter with round-robin / fixed / weighted round-robin grant
// and a read-return select FIFO that routes each readdatavalid back to its issuing master.
module avl_bus_n21_wrr #(
  parameter int unsigned MASTER_NUM     = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ARB_METHOD     = 0,
  parameter logic [63:0] WEIGHT_LIST    = 64'h1111_1111_1111_1111,
  parameter int unsigned SEL_FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rest,
  avl_bus_n21_wrr_if.arb bus,
  output logic           err_unexp_rdata
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int unsigned FA_W  = $clog2(SEL_FIFO_DEPTH);
  localparam int unsigned FC_W  = FA_W + 1;

  logic [PTR_W-1:0]      r_ptr;
  logic [3:0]            r_wcnt;
  logic [PTR_W-1:0]      r_fifo [SEL_FIFO_DEPTH];
  logic [FA_W-1:0]       r_wp;
  logic [FA_W-1:0]       r_rp;
  logic [FC_W-1:0]       r_fcnt;
  logic                  r_err;

  logic                  w_full;
  logic                  w_gnt_vld;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [MASTER_NUM-1:0] w_elig;
  logic [PTR_W-1:0]      w_start;
  logic [PTR_W-1:0]      w_gnt;
  logic [PTR_W-1:0]      w_gnt_nxt;
  logic [3:0]            w_wraw;
  logic [3:0]            w_weight;
  logic [3:0]            w_base;
  logic [4:0]            w_base_inc;

  function automatic logic [PTR_W-1:0] wrap_idx(logic [PTR_W-1:0] s, int unsigned k);
    return PTR_W'((32'(s) + k) % MASTER_NUM);
  endfunction

  // Full comes from the registered count so a same-cycle pop never frees a slot early.
  assign w_full  = (r_fcnt == FC_W'(SEL_FIFO_DEPTH));
  assign w_elig  = (bus.m_read | bus.m_write) & ~(bus.m_read & {MASTER_NUM{w_full}});
  assign w_start = (ARB_METHOD == 1) ? '0 : r_ptr;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int unsigned k = 0; k < MASTER_NUM; k++) begin
      if (!w_gnt_vld && w_elig[wrap_idx(w_start, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = wrap_idx(w_start, k);
      end
    end
  end

  always_comb begin
    bus.s_read        = 1'b0;
    bus.s_write       = 1'b0;
    bus.s_address     = '0;
    bus.s_byteenable  = '0;
    bus.s_writedata   = '0;
    bus.m_waitrequest = '1;
    if (w_gnt_vld) begin
      // A read+write on one master is illegal; the read wins.
      bus.s_read               = bus.m_read[w_gnt];
      bus.s_write              = bus.m_write[w_gnt] & ~bus.m_read[w_gnt];
      bus.s_address            = bus.m_address[32'(w_gnt) * ADDR_W +: ADDR_W];
      bus.s_byteenable         = bus.m_byteenable[32'(w_gnt) * BE_W +: BE_W];
      bus.s_writedata          = bus.m_writedata[32'(w_gnt) * DATA_W +: DATA_W];
      bus.m_waitrequest[w_gnt] = bus.s_waitrequest;
    end
  end

  assign w_accept = w_gnt_vld & ~bus.s_waitrequest;
  assign w_push   = w_accept & bus.m_read[w_gnt];
  assign w_pop    = bus.s_readdatavalid & (r_fcnt != '0);

  always_comb begin
    bus.m_readdatavalid = '0;
    if (w_pop) bus.m_readdatavalid[r_fifo[r_rp]] = 1'b1;
  end

  assign bus.m_readdata  = bus.s_readdata;
  assign err_unexp_rdata = r_err;

  assign w_wraw = 4'(WEIGHT_LIST >> (32'(w_gnt) * 4));

  always_comb begin
    w_weight = 4'd1;
    if (ARB_METHOD == 2 && w_wraw != 4'd0) w_weight = w_wraw;
  end

  assign w_base     = (w_gnt == r_ptr) ? r_wcnt : 4'd0;
  assign w_base_inc = {1'b0, w_base} + 5'd1;
  assign w_gnt_nxt  = (32'(w_gnt) == MASTER_NUM - 1) ? '0 : w_gnt + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rest) begin
      r_ptr  <= '0;
      r_wcnt <= '0;
    end else if (w_accept && ARB_METHOD != 1) begin
      if (w_base_inc < {1'b0, w_weight}) begin
        r_wcnt <= w_base_inc[3:0];
        r_ptr  <= w_gnt;
      end else begin
        r_wcnt <= '0;
        r_ptr  <= w_gnt_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + FA_W'(1);
      if (w_pop)  r_rp <= r_rp + FA_W'(1);
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + FC_W'(1);
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - FC_W'(1);
      if (bus.s_readdatavalid && r_fcnt == '0) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= w_gnt;
  end
endmodule

// File: tb/tb_avl_bus_n21_wrr.sv
// Bench for avl_bus_n21_wrr: three instances (round-robin, fixed, weighted) driven by shared
// master stimulus and checked every cycle against a queue-based reference model.
module tb_avl_bus_n21_wrr;
  localparam int NI = 3;
  localparam int          METH  [NI] = '{0, 1, 2};
  localparam int          DEPTH [NI] = '{8, 4, 4};
  localparam logic [63:0] WL    [NI] = '{64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111,
                                         64'h1111_1111_1111_4321};

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } ret_t;

  logic         clk;
  logic         rest;
  logic [3:0]   m_read, m_write;
  logic [127:0] m_address, m_writedata;
  logic [15:0]  m_be;
  logic         s_wait;
  logic         s_rdv   [NI];
  logic [31:0]  s_rdata [NI];

  logic         d_sread  [NI];
  logic         d_swrite [NI];
  logic         d_err    [NI];
  logic [31:0]  d_saddr  [NI];
  logic [31:0]  d_swdata [NI];
  logic [31:0]  d_mrdata [NI];
  logic [3:0]   d_sbe    [NI];
  logic [3:0]   d_mwait  [NI];
  logic [3:0]   d_mrdv   [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    avl_bus_n21_wrr_if #(.MASTER_NUM(4), .ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.m_read          = m_read;
    assign bus.m_write         = m_write;
    assign bus.m_address       = m_address;
    assign bus.m_byteenable    = m_be;
    assign bus.m_writedata     = m_writedata;
    assign bus.s_waitrequest   = s_wait;
    assign bus.s_readdata      = s_rdata[k];
    assign bus.s_readdatavalid = s_rdv[k];
    assign d_sread[k]  = bus.s_read;
    assign d_swrite[k] = bus.s_write;
    assign d_saddr[k]  = bus.s_address;
    assign d_sbe[k]    = bus.s_byteenable;
    assign d_swdata[k] = bus.s_writedata;
    assign d_mwait[k]  = bus.m_waitrequest;
    assign d_mrdv[k]   = bus.m_readdatavalid;
    assign d_mrdata[k] = bus.m_readdata;

    avl_bus_n21_wrr #(
      .MASTER_NUM(4), .ADDR_W(32), .DATA_W(32), .ARB_METHOD(METH[k]),
      .WEIGHT_LIST(WL[k]), .SEL_FIFO_DEPTH(DEPTH[k])
    ) u_dut (
      .clk(clk), .rest(rest), .bus(bus.arb), .err_unexp_rdata(d_err[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en, auto_ret, force_ret, lat_rand;
  int unsigned ret_pct;
  int unsigned cyc;

  // Reference model state
  int unsigned mptr [NI];
  int unsigned mcnt [NI];
  bit          merr [NI];
  int          mq   [NI][$];
  int          glog [NI][$];
  ret_t        sq   [NI][$];

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic int unsigned eff_w(input int k, input int g);
    int unsigned w;
    if (METH[k] == 0) return 1;
    w = int'((WL[k] >> (4 * g)) & 64'hF);
    return (w == 0) ? 1 : w;
  endfunction

  int          g, idx, start;
  bit          full;
  int unsigned base, w;
  logic        e_sr, e_sw;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be, e_wait, e_rdv;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        full  = (mq[k].size() >= DEPTH[k]);
        start = (METH[k] == 1) ? 0 : int'(mptr[k]);
        g = -1;
        for (int j = 0; j < 4; j++) begin
          idx = (start + j) % 4;
          if (g < 0 && (m_read[idx] || m_write[idx]) && !(m_read[idx] && full)) g = idx;
        end
        e_sr = 0; e_sw = 0; e_addr = 0; e_be = 0; e_wd = 0; e_wait = 4'hF; e_rdv = 0;
        if (g >= 0) begin
          e_sr      = m_read[g];
          e_sw      = m_write[g] && !m_read[g];
          e_addr    = m_address[g*32 +: 32];
          e_be      = m_be[g*4 +: 4];
          e_wd      = m_writedata[g*32 +: 32];
          e_wait[g] = s_wait;
        end
        if (s_rdv[k] && mq[k].size() > 0) e_rdv[mq[k][0]] = 1'b1;
        chk("s_read", k, 64'(d_sread[k]), 64'(e_sr));
        chk("s_write", k, 64'(d_swrite[k]), 64'(e_sw));
        chk("s_address", k, 64'(d_saddr[k]), 64'(e_addr));
        chk("s_byteenable", k, 64'(d_sbe[k]), 64'(e_be));
        chk("s_writedata", k, 64'(d_swdata[k]), 64'(e_wd));
        chk("m_waitrequest", k, 64'(d_mwait[k]), 64'(e_wait));
        chk("m_readdatavalid", k, 64'(d_mrdv[k]), 64'(e_rdv));
        chk("m_readdata", k, 64'(d_mrdata[k]), 64'(s_rdata[k]));
        chk("err_unexp_rdata", k, 64'(d_err[k]), 64'(merr[k]));
        if (rest) begin
          mptr[k] = 0; mcnt[k] = 0; merr[k] = 0;
          mq[k].delete();
          sq[k].delete();
        end else begin
          if (s_rdv[k]) begin
            if (mq[k].size() > 0) void'(mq[k].pop_front());
            else merr[k] = 1;
          end
          if (g >= 0 && !s_wait) begin
            glog[k].push_back(g);
            if (m_read[g]) begin
              mq[k].push_back(g);
              sq[k].push_back('{m_address[g*32 +: 32], cyc + (lat_rand ? $urandom_range(1, 4) : 2)});
            end
            if (METH[k] != 1) begin
              base = (g == int'(mptr[k])) ? mcnt[k] : 0;
              w    = eff_w(k, g);
              if (base + 1 < w) begin
                mcnt[k] = base + 1;
                mptr[k] = g;
              end else begin
                mcnt[k] = 0;
                mptr[k] = (g + 1) % 4;
              end
            end
          end
        end
      end
    end
  end

  task automatic drive_slave();
    for (int k = 0; k < NI; k++) begin
      bit rv;
      rv = force_ret;
      if (auto_ret && sq[k].size() > 0 && sq[k][0].due <= cyc &&
          $urandom_range(0, 99) < ret_pct) rv = 1;
      s_rdv[k]   = rv;
      s_rdata[k] = $urandom;
      if (rv && sq[k].size() > 0) begin
        s_rdata[k] = sq[k][0].addr;
        void'(sq[k].pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_slave();
  endtask

  task automatic set_m(input logic [3:0] rd, input logic [3:0] wr);
    m_read  = rd;
    m_write = wr;
    for (int i = 0; i < 4; i++) begin
      m_address[i*32 +: 32]   = $urandom;
      m_writedata[i*32 +: 32] = $urandom;
      m_be[i*4 +: 4]          = 4'($urandom);
    end
  endtask

  // seq lists expected grants left to right, one hex digit each
  task automatic chk_log(input string nm, input int k, input int n, input logic [63:0] seq);
    chk({nm, "_len_ok"}, k, 64'(glog[k].size() >= n), 64'd1);
    for (int j = 0; j < n; j++) begin
      if (j < glog[k].size()) chk(nm, k, 64'(glog[k][j]), (seq >> (4 * (n - 1 - j))) & 64'hF);
    end
  endtask

  task automatic clear_logs();
    for (int k = 0; k < NI; k++) glog[k].delete();
  endtask

  initial begin
    chk_en = 0; auto_ret = 0; force_ret = 0; lat_rand = 0; ret_pct = 100; cyc = 0;
    rest = 1'b1; s_wait = 1'b0;
    for (int k = 0; k < NI; k++) begin
      s_rdv[k] = 1'b0; s_rdata[k] = '0; mptr[k] = 0; mcnt[k] = 0; merr[k] = 0;
    end
    set_m(4'h0, 4'h0);

    // Reset
    step();
    chk_en = 1;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_m_waitrequest", k, 64'(d_mwait[k]), 64'hF);
      chk("rst_s_read", k, 64'(d_sread[k]), 64'd0);
      chk("rst_s_write", k, 64'(d_swrite[k]), 64'd0);
      chk("rst_m_readdatavalid", k, 64'(d_mrdv[k]), 64'd0);
      chk("rst_err", k, 64'(d_err[k]), 64'd0);
    end
    step();
    rest = 1'b0;

    // Round-robin and weighted round-robin, with a 3-cycle slave stall mid-sequence
    clear_logs();
    auto_ret = 1;
    for (int i = 0; i < 20; i++) begin
      s_wait = (i >= 5 && i < 8);
      set_m(4'hF, 4'h0);
      step();
    end
    chk_log("rr_seq", 0, 12, 64'h0123_0123_0123);
    chk_log("wrr_seq", 2, 12, 64'h0112_2233_3301);
    s_wait = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_m(4'h0, 4'h0);
      step();
    end

    // Fixed priority: masters 1 and 3 write, then master 1 drops
    clear_logs();
    for (int i = 0; i < 13; i++) begin
      set_m(4'h0, (i < 10) ? 4'b1010 : 4'b1000);
      step();
    end
    chk_log("fp_seq", 1, 13, 64'h1_1111_1111_1333);

    // FIFO full on the depth-4 fixed-priority instance; master 2 writes still flow
    clear_logs();
    auto_ret = 0;
    for (int i = 0; i < 8; i++) begin
      set_m(4'b0001, 4'b0100);
      step();
    end
    set_m(4'b0001, 4'b0100);
    @(negedge clk);
    chk("full_rd_wait", 1, 64'(d_mwait[1][0]), 64'd1);
    chk("full_wr_go", 1, 64'(d_swrite[1]), 64'd1);
    force_ret = 1;
    step();
    force_ret = 0;
    for (int i = 0; i < 3; i++) begin
      set_m(4'b0001, 4'b0100);
      step();
    end
    chk_log("full_seq", 1, 12, 64'h0000_2222_2202);
    auto_ret = 1;
    for (int i = 0; i < 12; i++) begin
      set_m(4'h0, 4'h0);
      step();
    end

    // Random traffic with random latency, stalls and throttled returns
    lat_rand = 1;
    ret_pct = 40;
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] rd, wr;
      rd = 4'($urandom);
      wr = 4'($urandom);
      if ($urandom_range(0, 9) != 0) wr = wr & ~rd;
      s_wait = ($urandom_range(0, 99) < 25);
      set_m(rd, wr);
      step();
    end
    s_wait = 1'b0;
    ret_pct = 100;
    for (int i = 0; i < 30; i++) begin
      set_m(4'h0, 4'h0);
      step();
    end

    // Spurious return with the FIFO empty, then reset clears the flag
    for (int k = 0; k < NI; k++) chk("drained", k, 64'(mq[k].size()), 64'd0);
    force_ret = 1;
    step();
    force_ret = 0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("spur_no_rdv", k, 64'(d_mrdv[k]), 64'd0);
    step();
    step();
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("spur_err_sticky", k, 64'(d_err[k]), 64'd1);
    rest = 1'b1;
    step();
    rest = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("err_cleared", k, 64'(d_err[k]), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
